// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner codes,
// wait-counter width and the round-robin grant decision.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    // Wait counter is wide enough for 0..15 extra cycles.
    localparam int CNT_W = 4;

    typedef struct packed {
        logic valid;
        logic who;
    } grant_t;

    // Round-robin pick between two eligible requesters; on a tie the one
    // that did not win last time is granted.
    function automatic grant_t pick_grant(input logic cpu_ok,
                                          input logic ldr_ok,
                                          input logic last_grant);
        grant_t g;
        g.valid = cpu_ok | ldr_ok;
        if (cpu_ok && ldr_ok) begin
            g.who = ~last_grant;
        end else if (ldr_ok) begin
            g.who = OWN_LDR;
        end else begin
            g.who = OWN_CPU;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Wait-state counter: loaded at grant, counts down once per cycle while
// enabled, and flags zero when the access may complete.
module mem_wait_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Count register: load takes priority over decrement.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: shares one byte-wide memory between the core and
// the loader, round-robin with a core lock for indivisible fetch bursts, and
// a programmable number of wait states per access. All outputs registered.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_done,
    output logic [7:0]        cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_wdata,
    output logic              ldr_done,
    output logic [7:0]        ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              owner
);

    state_t            state_q;
    state_t            state_d;
    logic              lock_q;
    logic              last_q;
    grant_t            grant;
    logic              do_grant;
    logic              do_finish;
    logic              cnt_zero;
    logic              cnt_dec;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_wdata;

    mem_wait_counter u_wait (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (do_grant),
        .load_value (CNT_W'(WAIT_CYCLES)),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    assign cnt_dec = (state_q == ST_ACCESS) && !cnt_zero;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, arbitration and the grantee's command fields.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        do_grant  = 1'b0;
        do_finish = 1'b0;
        grant     = pick_grant(cpu_req, ldr_req && !lock_q, last_q);
        sel_we    = (grant.who == OWN_CPU) ? cpu_we    : ldr_we;
        sel_addr  = (grant.who == OWN_CPU) ? cpu_addr  : ldr_addr;
        sel_wdata = (grant.who == OWN_CPU) ? cpu_wdata : ldr_wdata;
        unique case (state_q)
            ST_IDLE: begin
                if (grant.valid) begin
                    do_grant = 1'b1;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_zero) begin
                    do_finish = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                // Requests seen here are ignored; this avoids a duplicate
                // access when a requester keeps req high after done.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered memory interface, ownership, lock and completion outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= OWN_CPU;
            last_q    <= OWN_LDR;
            lock_q    <= 1'b0;
            cpu_done  <= 1'b0;
            ldr_done  <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            cpu_done <= 1'b0;
            ldr_done <= 1'b0;
            if (do_grant) begin
                mem_en    <= 1'b1;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                owner     <= grant.who;
                last_q    <= grant.who;
                lock_q    <= (grant.who == OWN_CPU) ? cpu_lock : 1'b0;
            end else if (state_q == ST_IDLE && lock_q && !cpu_req) begin
                // Core walked away mid-burst: release the lock.
                lock_q <= 1'b0;
            end
            if (do_finish) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                if (owner == OWN_CPU) begin
                    cpu_done <= 1'b1;
                    if (!mem_we) begin
                        cpu_rdata <= mem_rdata;
                    end
                end else begin
                    ldr_done <= 1'b1;
                    if (!mem_we) begin
                        ldr_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide instruction/data memory between two requesters:
  - the processor core, which does four byte fetches per instruction plus lb/sb accesses;
  - the program loader/debug port.
- Sequences every memory access and inserts a programmable number of wait states.
- Arbitration is round-robin. A core lock keeps the four-byte fetch burst indivisible.
- Sits between the core/loader and the memory macro.

Parameters:
ADDR_W, 8, memory address width in bits
WAIT_CYCLES, 0, extra cycles mem_en is held per access (0..15)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  core request; held with cmd fields stable until cpu_done
cpu_we  in  1  core write (sb) when 1, read otherwise
cpu_lock  in  1  core holds ownership after this access (fetch bytes 0-2)
cpu_addr  in  ADDR_W  core byte address
cpu_wdata  in  8  core write data
cpu_done  out  1  one-cycle completion pulse to core
cpu_rdata  out  8  read data, valid while cpu_done=1 and held until next core read completes
ldr_req  in  1  loader request, same rules as cpu_req
ldr_we  in  1  loader write
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  8  loader write data
ldr_done  out  1  one-cycle completion pulse to loader
ldr_rdata  out  8  loader read data, same hold rule
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data, valid during last mem_en cycle
owner  out  1  0=core, 1=loader; current or last grant

Behaviour:
- Clocking and reset: one clock (clock). Reset is asynchronous and active-low (reset_n).
- All outputs are registered.
- Reset values: every output 0, state IDLE, wait counter 0, lock flag 0, last_grant=1 so the core wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples requests.
  - Lock flag set: only cpu_req is eligible.
  - Otherwise, a single requester is granted.
  - Both requesting: grant the one not equal to last_grant.
  - On grant:
    - latch addr/we/wdata into mem_*;
    - mem_en=1; owner=grantee; last_grant=grantee; counter=WAIT_CYCLES;
    - lock flag = cpu_lock if the grantee is the core, else 0;
    - go to ACCESS.
- ACCESS:
  - counter!=0: decrement and hold all mem_* signals.
  - counter==0:
    - capture mem_rdata into the grantee's rdata (reads only; writes leave rdata unchanged);
    - mem_en=0, mem_we=0;
    - assert the grantee's done;
    - go to DONE.
- DONE:
  - done deasserts; return to IDLE.
  - Requests present during DONE are ignored, so a requester may keep req high back-to-back without a duplicate access.
- Latency: req sampled at edge N → mem_en high from N. done high in cycle N+1+WAIT_CYCLES. Earliest next grant at edge N+3+WAIT_CYCLES.
- Writes: mem_we stays high for all WAIT_CYCLES+1 cycles; memory rewriting the same byte is harmless.
- Lock:
  - A core access with cpu_lock=1 keeps the lock flag set through DONE.
  - The loader is blocked until a core access with cpu_lock=0 completes.
  - If the core drops cpu_req while the lock flag is set, the lock flag clears in IDLE and arbitration resumes.
- Requests deasserted during ACCESS: the access still completes and done still pulses (no abort).
- reset_n low mid-access: immediate return to reset values. No done pulse. A partially held write carries no guarantee.
- Exactly one of cpu_done/ldr_done may be high in any cycle.

Decomposition:
- Shared package: state encoding constants (IDLE/ACCESS/DONE) and owner codes OWN_CPU=0, OWN_LDR=1. The core control unit and the loader also use these.
- One natural sub-module: mem_wait_counter (load value, decrement, zero flag).

Test Plan:
- WAIT=0: core read at addr 0x10 with memory holding 0x3C → mem_en high one cycle, cpu_done one cycle later, cpu_rdata=0x3C, ldr_done stays 0.
- WAIT=2: loader write 0xA5 to 0x20 → mem_en/mem_we high 3 cycles with mem_addr=0x20 and mem_wdata=0xA5; ldr_done in cycle N+3; ldr_rdata unchanged.
- Both requesting continuously from reset → grants alternate core, loader, core, loader; each done spaced 3 cycles at WAIT=0.
- Core issues 4 fetches (lock=1,1,1,0) at 0x00-0x03 while ldr_req is held high → four consecutive core grants, then the loader is granted.
- reset_n pulled low during ACCESS of a core read → all outputs 0 asynchronously, no cpu_done; after release with both requesting, the core is granted first.
- Back-to-back core reads with cpu_req held high → exactly one access per done, no duplicate access from the DONE cycle.
